// File: rtl/seg_display_driver.sv
// Signed binary to 8-digit 7-segment driver: a shift-add-3 (double-dabble) converter
// feeds seven magnitude digits (hex0 = ones) plus a sign digit on hex7.
module seg_display_driver #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             update,
  output logic             busy,
  output logic             done,
  output logic [0:6]       hex0,
  output logic [0:6]       hex1,
  output logic [0:6]       hex2,
  output logic [0:6]       hex3,
  output logic [0:6]       hex4,
  output logic [0:6]       hex5,
  output logic [0:6]       hex6,
  output logic [0:6]       hex7
);

  // Enough BCD nibbles to hold the largest WIDTH-bit magnitude.
  localparam int NIB    = (WIDTH * 301) / 1000 + 1;
  localparam int BCD_W  = 4 * NIB;
  localparam int ITER_W = $clog2(WIDTH);

  localparam logic [0:6] SEG_ZERO  = 7'b0000001;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic              sign;
  logic [WIDTH-1:0]  mag;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [ITER_W-1:0] iter;
  logic              pend;
  logic [WIDTH-1:0]  pend_val;
  logic [WIDTH-1:0]  src;
  logic [WIDTH-1:0]  src_mag;
  logic [0:6]        seg_q [DIGITS];
  logic [0:6]        sign_seg;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = 7'b0110000;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NIB; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A fresh update at the COMMIT edge is newer than the pending slot, so it wins.
  always_comb begin
    src = value;
    if (state == COMMIT && !update) src = pend_val;
    src_mag = src[WIDTH-1] ? (~src + WIDTH'(1)) : src;
  end

  // Handshake: update is a level request sampled on every rising edge; busy is high
  // from the accepting edge until COMMIT retires the last queued request, and done
  // is a single-cycle pulse marking the cycle in which hex0..hex7 were refreshed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      iter     <= '0;
      sign_seg <= SEG_BLANK;
      for (int i = 0; i < DIGITS; i++) seg_q[i] <= SEG_ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (update) begin
            sign  <= src[WIDTH-1];
            mag   <= src_mag;
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          if (update) begin
            pend     <= 1'b1;
            pend_val <= value;
          end
          {bcd, mag} <= {bcd_adj[BCD_W-2:0], mag, 1'b0};
          iter       <= iter + ITER_W'(1);
          if (iter == ITER_W'(WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          for (int i = 0; i < DIGITS; i++) seg_q[i] <= seg7(bcd[4*i +: 4]);
          sign_seg <= sign ? SEG_MINUS : SEG_BLANK;
          done     <= 1'b1;
          if (pend || update) begin
            sign  <= src[WIDTH-1];
            mag   <= src_mag;
            bcd   <= '0;
            iter  <= '0;
            pend  <= 1'b0;
            busy  <= 1'b1;
            state <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign hex0 = seg_q[0];
  assign hex1 = seg_q[1];
  assign hex2 = seg_q[2];
  assign hex3 = seg_q[3];
  assign hex4 = seg_q[4];
  assign hex5 = seg_q[5];
  assign hex6 = seg_q[6];
  assign hex7 = sign_seg;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: directed values with hand-computed BCD digits, a
// queue-based scoreboard checked by a done-triggered monitor, plus timing/reset checks.
`timescale 1ns/1ps
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        update;
  logic        busy;
  logic        done;
  logic [0:6]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [55:0] obs;

  int tests  = 0;
  int failed = 0;
  logic [55:0] exp_q[$];

  seg_display_driver dut (
    .clk(clk), .rst(rst), .value(value), .update(update),
    .busy(busy), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign obs = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0001100;
      default: return 7'b0110000;
    endcase
  endfunction

  function automatic logic [55:0] exp_vec(input logic [27:0] bcd, input logic neg);
    logic [55:0] v;
    for (int i = 0; i < 7; i++) v[7*i +: 7] = seg_ref(bcd[4*i +: 4]);
    v[49 +: 7] = neg ? 7'b1111110 : 7'b1111111;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [55:0] prev_obs;
  logic        done_q = 1'b0;
  logic        hex_changed = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_obs    = obs;
      hex_changed = 1'b0;
      done_q      = 1'b0;
    end else begin
      if (!done && obs !== prev_obs) hex_changed = 1'b1;
      if (done) begin
        check("done_width", done_q, 1'b0);
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_done: got hex %h with empty expected queue", obs);
        end else begin
          logic [55:0] e;
          e = exp_q.pop_front();
          check("hex_data", obs, e);
          check("hex_stable_conv", hex_changed, 1'b0);
        end
        hex_changed = 1'b0;
      end
      done_q   = done;
      prev_obs = obs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_conv(input logic [31:0] v, input logic [27:0] bcd, input logic neg);
    int k;
    int bc;
    exp_q.push_back(exp_vec(bcd, neg));
    @(negedge clk);
    value  = v;
    update = 1'b1;
    k  = 0;
    bc = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      update = 1'b0;
      k++;
      if (busy) bc++;
      if (done) break;
    end
    check("done_latency", k - 1, 33);
    check("busy_cycles", bc, 33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d1, d2, dn;
    rst    = 1'b0;
    update = 1'b0;
    value  = '0;
    repeat (3) @(negedge clk);
    check("reset_hex", obs, exp_vec(28'h0000000, 1'b0));
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // T1..T3 and extra directed corners
    run_conv(32'd12345,      28'h0012345, 1'b0);
    run_conv(32'hFFFF_FFFF,  28'h0000001, 1'b1);
    run_conv(32'd0,          28'h0000000, 1'b0);
    run_conv(32'h8000_0000,  28'h7483648, 1'b1);
    run_conv(32'd10000000,   28'h0000000, 1'b0);
    run_conv(32'hFFFF_CFC7,  28'h0012345, 1'b1);
    run_conv(32'd9999999,    28'h9999999, 1'b0);
    run_conv(32'hFF67_6980,  28'h0000000, 1'b1);
    run_conv(32'h7FFF_FFFF,  28'h7483647, 1'b0);
    run_conv(32'd123456789,  28'h3456789, 1'b0);

    // T4: back-to-back with pending overwrite
    exp_q.push_back(exp_vec(28'h0000009, 1'b0));
    exp_q.push_back(exp_vec(28'h0000077, 1'b0));
    @(negedge clk);
    value  = 32'd9;
    update = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      update = 1'b0;
      if (k == 10) begin value = 32'd42; update = 1'b1; end
      if (k == 20) begin value = 32'd77; update = 1'b1; end
      if (done) begin
        if (d1 == 0) begin
          d1 = k;
          check("t4_busy_at_first_done", busy, 1'b1);
        end else if (d2 == 0) begin
          d2 = k;
        end
      end
      if (d2 != 0) break;
    end
    check("t4_first_done", d1 - 1, 33);
    check("t4_second_done", d2 - 1, 66);
    repeat (3) @(negedge clk);

    // T5: reset mid-conversion
    @(negedge clk);
    value  = 32'd555;
    update = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      update = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check("t5_reset_hex", obs, exp_vec(28'h0000000, 1'b0));
    check("t5_reset_busy", busy, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t5_no_done", dn, 0);
    check("t5_hex_held", obs, exp_vec(28'h0000000, 1'b0));
    check("t5_busy_idle", busy, 1'b0);

    // recovery after abort
    run_conv(32'd4096, 28'h0004096, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
